// File: rtl/block_modn_counter.sv
// block_modn_counter: modulo-MOD up/down counter advanced by a two-speed prescaler,
// with synchronous load, enable, and registered tick / terminal-count pulses.
module block_modn_counter #(
    parameter int MOD      = 20,
    parameter int W        = 5,
    parameter int DIV_FAST = 12_500_000,
    parameter int DIV_SLOW = 50_000_000
) (
    input  logic         clk_50M,
    input  logic         reset,
    input  logic         S0,
    input  logic         S1,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] Output,
    output logic         tick,
    output logic         tc
);
    localparam int DIV_MAX = DIV_FAST > DIV_SLOW ? DIV_FAST : DIV_SLOW;
    localparam int PW = DIV_MAX > 1 ? $clog2(DIV_MAX) : 1;
    localparam logic [PW-1:0] FAST_TOP = PW'(DIV_FAST - 1);
    localparam logic [PW-1:0] SLOW_TOP = PW'(DIV_SLOW - 1);
    localparam logic [W-1:0]  MOD_TOP  = W'(MOD - 1);
    localparam logic [W:0]    MOD_EXT  = (W + 1)'(MOD);
    logic [PW-1:0] psc_q, psc_d, top;
    logic [W-1:0]  cnt_q, cnt_d;
    logic          s1_q, s1_d, tick_q, tick_d, tc_q, tc_d;
    logic          s1_chg, adv, wrap, over;
    always_comb begin
        top    = S1 ? FAST_TOP : SLOW_TOP;
        s1_chg = S1 != s1_q;
        adv    = en && !load && !s1_chg && psc_q >= top;
        wrap   = S0 ? cnt_q == '0 : cnt_q == MOD_TOP;
        over   = {1'b0, load_val} >= MOD_EXT;
        psc_d  = (load || (en && (s1_chg || adv))) ? '0 : en ? psc_q + 1'b1 : psc_q;
        s1_d   = en ? S1 : s1_q;
        // load wins over any advance; out-of-range loads saturate to MOD-1
        cnt_d  = load ? (over ? MOD_TOP : load_val)
               : !adv ? cnt_q
               : wrap ? (S0 ? MOD_TOP : '0)
               : S0   ? cnt_q - 1'b1 : cnt_q + 1'b1;
        tick_d = adv;
        tc_d   = adv && wrap;
    end
    always_ff @(posedge clk_50M) begin
        if (reset) begin
            psc_q  <= '0;
            cnt_q  <= '0;
            s1_q   <= S1;
            tick_q <= 1'b0;
            tc_q   <= 1'b0;
        end else begin
            psc_q  <= psc_d;
            cnt_q  <= cnt_d;
            s1_q   <= s1_d;
            tick_q <= tick_d;
            tc_q   <= tc_d;
        end
    end
    assign Output = cnt_q;
    assign tick   = tick_q;
    assign tc     = tc_q;
endmodule

// File: tb/tb_block_modn_counter.sv
// tb_block_modn_counter: directed-vector bench for block_modn_counter (MOD=20, DIV 2/5).
module tb_block_modn_counter;
    typedef struct {
        logic       en, s0, s1, ld;
        logic [4:0] lv, out;
        logic       tk, tc;
    } vec_t;
    logic       clk = 1'b0, reset = 1'b1, s0 = 1'b0, s1 = 1'b1, en = 1'b0, load = 1'b0;
    logic [4:0] lv = '0, out;
    logic       tick, tc;
    int         checks = 0, errors = 0;
    vec_t       v[$];
    always #5 clk = ~clk;
    block_modn_counter #(.MOD(20), .W(5), .DIV_FAST(2), .DIV_SLOW(5)) dut (
        .clk_50M(clk), .reset(reset), .S0(s0), .S1(s1), .en(en), .load(load),
        .load_val(lv), .Output(out), .tick(tick), .tc(tc)
    );
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", n, a, e);
        end
    endtask
    task automatic check3(input string n, input int o, input int t, input int c);
        chk({n, " out"}, {27'd0, out}, o);
        chk({n, " tick"}, {31'd0, tick}, t);
        chk({n, " tc"}, {31'd0, tc}, c);
    endtask
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic add(input int e, input int d, input int s, input int l, input int x,
                       input int o, input int t, input int c);
        vec_t r;
        r.en = e[0]; r.s0 = d[0]; r.s1 = s[0]; r.ld = l[0];
        r.lv = x[4:0]; r.out = o[4:0]; r.tk = t[0]; r.tc = c[0];
        v.push_back(r);
    endtask
    initial begin
        // {en, S0, S1, load, load_val} -> {Output, tick, tc} after one edge
        add(1,1,1,0,0,  0,0,0); add(1,1,1,0,0, 19,1,1);
        add(1,1,1,0,0, 19,0,0); add(1,1,1,0,0, 18,1,0);
        add(1,0,0,0,0, 18,0,0); add(1,0,0,0,0, 18,0,0);
        add(1,0,0,0,0, 18,0,0); add(1,0,0,0,0, 18,0,0);
        add(1,0,0,0,0, 18,0,0); add(1,0,0,0,0, 19,1,0);
        add(1,0,0,0,0, 19,0,0); add(1,0,0,0,0, 19,0,0);
        add(1,0,1,0,0, 19,0,0); add(1,0,1,0,0, 19,0,0);
        add(1,0,1,0,0,  0,1,1);
        add(1,0,1,0,0,  0,0,0); add(1,0,1,1,7,  7,0,0);
        add(1,0,1,0,0,  7,0,0); add(1,0,1,0,0,  8,1,0);
        add(1,0,1,1,25,19,0,0); add(1,0,1,0,0, 19,0,0);
        add(1,0,1,0,0,  0,1,1);
        add(1,0,0,0,0,  0,0,0); add(1,0,0,0,0,  0,0,0);
        add(1,0,0,0,0,  0,0,0);
        for (int i = 0; i < 10; i++) add(0, i % 2, i / 5, 0, 0, 0, 0, 0);
        add(1,0,0,0,0,  0,0,0); add(1,0,0,0,0,  0,0,0);
        add(1,0,0,0,0,  1,1,0);
        add(0,0,0,1,13,13,0,0);
        add(1,0,1,0,0, 13,0,0); add(1,0,1,0,0, 13,0,0);
        step;
        check3("reset", 0, 0, 0);
        reset = 1'b0; en = 1'b1; s0 = 1'b0; s1 = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            step;
            check3($sformatf("up%0d", i), (i / 2) % 20, int'(i % 2 == 0), int'(i == 40));
        end
        foreach (v[i]) begin
            en = v[i].en; s0 = v[i].s0; s1 = v[i].s1; load = v[i].ld; lv = v[i].lv;
            step;
            check3($sformatf("vec%0d", i), v[i].out, v[i].tk, v[i].tc);
        end
        load = 1'b0; reset = 1'b1;
        step;
        check3("midrst", 0, 0, 0);
        reset = 1'b0;
        step;
        check3("rel1", 0, 0, 0);
        step;
        check3("rel2", 1, 1, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/block_modn_counter.md
BLOCK_MODN_COUNTER -- requirements
Module: block_modn_counter

Interface
REQ-001 The block SHALL expose parameter MOD, default 20, the counter modulus; legal range 2..2**W.
REQ-002 The block SHALL expose parameter W, default 5, the counter output width.
REQ-003 The block SHALL expose parameter DIV_FAST, default 12_500_000, the clk_50M cycles per count tick when S1=1; minimum 1.
REQ-004 The block SHALL expose parameter DIV_SLOW, default 50_000_000, the clk_50M cycles per count tick when S1=0; minimum 1.
REQ-005 The block SHALL have one clock; reset is synchronous and active-high.
REQ-006 clk_50M  input  1  system clock; all state updates on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 S0  input  1  direction: 0 = count up, 1 = count down.
REQ-009 S1  input  1  speed select: 1 = DIV_FAST, 0 = DIV_SLOW.
REQ-010 en  input  1  count enable; 0 freezes the prescaler and the counter.
REQ-011 load  input  1  synchronous load strobe.
REQ-012 load_val  input  W  value to load.
REQ-013 Output  output  W  registered counter value, always in 0..MOD-1.
REQ-014 tick  output  1  registered one-cycle pulse marking each counter advance.
REQ-015 tc  output  1  registered one-cycle terminal-count (wrap) pulse.

Function
REQ-016 The prescaler SHALL count 0..DIV-1, where DIV is selected by S1 sampled each cycle; on reaching DIV-1 with en=1, it SHALL return to 0 and assert the internal advance strobe for that cycle.
REQ-017 With DIV=1, the advance strobe SHALL assert on every cycle in which en=1.
REQ-018 The block SHALL register S1; when S1 differs from its registered value, the prescaler SHALL clear to 0 and no advance SHALL occur that cycle.
REQ-019 When en=0, the prescaler, Output and S1 history SHALL hold; tick and tc SHALL be 0.
REQ-020 On an advance with S0=0, Output SHALL increment, and Output=MOD-1 SHALL wrap to 0.
REQ-021 On an advance with S0=1, Output SHALL decrement, and Output=0 SHALL wrap to MOD-1.
REQ-022 tick SHALL be 1 in the cycle after each advance (coincident with the new Output value) and 0 otherwise.
REQ-023 tc SHALL be 1 in the same cycle as tick whenever that advance wrapped (up MOD-1->0, down 0->MOD-1), and 0 otherwise.
REQ-024 load=1 SHALL override any advance, regardless of en or the prescaler state.
- Output <= load_val, or MOD-1 if load_val >= MOD.
- Prescaler <= 0.
- tick = 0 and tc = 0 in the following cycle.
REQ-025 A change of S0 SHALL take effect at the next advance, with no extra or lost count.
REQ-026 Priority SHALL be reset > load > S1-change prescaler clear > advance.
REQ-027 Arithmetic SHALL be modulo MOD within W bits; Output SHALL never leave 0..MOD-1.

Reset
REQ-028 When reset=1 at a clk_50M edge, the following SHALL take effect on that edge, overriding all other inputs:
- Output = 0, tick = 0, tc = 0.
- Prescaler = 0.
- Registered S1 = current S1.
REQ-029 A reset during an operation SHALL discard any pending advance; the first advance after release SHALL occur DIV cycles after release, given en=1.

Verification
REQ-030 The bench SHALL cover these scenarios, using MOD=20, W=5, DIV_FAST=2, DIV_SLOW=5:
- Reset, then en=1, S0=0, S1=1 for 40 cycles -> tick every 2nd cycle, Output 0,1,...,19,0; tc=1 only with Output=0 after 19.
- S0=1 from Output=0 -> next tick gives Output=19 with tc=1, then 18, with tc=0.
- S1=0 -> tick spacing is 5 cycles; toggle S1 mid-period -> prescaler clears, next tick comes DIV cycles after the toggle.
- load=1, load_val=7 concurrent with an advance -> Output=7, tick=0; load_val=25 -> Output=19.
- en=0 for 10 cycles mid-period -> Output, tick and tc frozen/0; after resume, the remaining prescaler count completes.
- Assert reset with Output=13 mid-period -> next cycle Output=0, tick=0, tc=0; with S1=1, first tick 2 cycles after release.
